dds_freq_detector: RTL
======================

Name: dds_freq_detector

Overview:
- Receive-side companion to the DDS sin/cos generator.
- Consumes a stream of quadrature samples (sin, cos) and recovers the 4-bit frequency control word that produced them.
- Counts phase wraps over a window of exactly 2^WIN_LOG2 accepted samples; each window yields one estimate.
- Reports lock when consecutive estimates agree. Used for loopback self-test of the generator and for tone identification.

Parameters:
ROM_AW, 8, phase accumulator width of the source generator; full phase cycle = 2^ROM_AW samples at k=1
ROM_DW, 8, sample magnitude width; samples are ROM_DW+1 bits, two's complement
WIN_LOG2, 8, log2 of measurement window in accepted samples; must equal ROM_AW for k_out to equal the source step
CNT_W, 5, width of the wrap counter; saturates at 2^CNT_W-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active high
ce  input  1  clock enable; all state holds when low
s_valid  input  1  sample valid
s_ready  output  1  sample ready; low only in REPORT state
sin_in  input  ROM_DW+1  sin sample, signed
cos_in  input  ROM_DW+1  cos sample, signed
k_out  output  4  recovered step word
k_valid  output  1  one-cycle pulse: new k_out available
k_ovf  output  1  wrap count exceeded 15 in last window
lock  output  1  two consecutive windows gave equal, non-overflow results

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Accept rule: a sample is accepted on a rising clk edge where ce & s_valid & s_ready.
- Reset values:
  - Outputs: k_out=0, k_valid=0, k_ovf=0, lock=0, s_ready=1.
  - Internal: state=SEED, prev_q=0, win_cnt=0, wrap_cnt=0, last_k=0, last_ok=0.
  - Reset wins over ce and over every other event in the same cycle. Reset mid-window discards the partial count.
- Quadrant: q = {sin_in[MSB], cos_in[MSB]}. Sign bit 0 means value >= 0.
- Wrap event: prev_q==2'b10 (sin<0, cos>=0) and current q==2'b00 (sin>=0, cos>=0).
  - Detected combinationally on the accepted sample.
  - Valid for steps < 2^(ROM_AW-2). All 4-bit steps are within this limit.
- SEED state:
  - First accepted sample only loads prev_q. No count, no window increment.
  - Next state is MEAS.
- MEAS state, per accepted sample:
  - prev_q <= q.
  - wrap_cnt increments on a wrap event, saturating at 2^CNT_W-1.
  - win_cnt increments, WIN_LOG2+1 bits wide.
  - On the sample that makes win_cnt == 2^WIN_LOG2, the increment for that sample is included and the state moves to REPORT.
- REPORT state (exactly one cycle when ce=1; holds while ce=0):
  - s_ready=0.
  - k_out <= wrap_cnt[3:0], or 4'hF if wrap_cnt > 15.
  - k_ovf <= (wrap_cnt > 15).
  - k_valid=1 for this cycle only.
  - lock <= last_ok & ~ovf & (wrap_cnt[3:0] == last_k).
  - last_k <= wrap_cnt[3:0]; last_ok <= ~ovf.
  - wrap_cnt and win_cnt clear. prev_q is retained, so windows abut with no lost transition.
  - Next state is MEAS, not SEED.
- Latency: k_valid asserts on the cycle after the clock edge that accepted the 2^WIN_LOG2-th sample of the window.
- k_out, k_ovf and lock hold between reports.
- lock drops on the first mismatching or overflowing report.
- s_valid low in MEAS: counters hold; no timeout.
- ce low: no accepts, no state change. k_valid stays high if ce falls during REPORT, and deasserts after the first ce=1 cycle.
- Exactness: with contiguous samples from a source at step k, each window spans exactly k full phase cycles, so wrap_cnt == k. This holds for any start phase because the transition across the window boundary is counted once.
- k=0 (static phase): wrap_cnt=0, k_out=0. Lock is valid on the second window.

Test Plan:
- Generator loopback, kin=3, ROM_AW=8, continuous valid: k_valid pulses every 257 cycles after the 1-cycle seed. Every report has k_out=3; lock=1 from the second report.
- kin=1 with start phase 200 (mid quadrant 4): first report k_out=1, no double count across the boundary. Repeat for start phases 0, 64, 128, 192: all give 1.
- kin changed 5->9 mid-window: the straddled window reports a value from 5 to 9 with lock=0. The next window reports 9 with lock=0; the one after reports 9 with lock=1.
- Synthetic stream with 20 quadrant 2'b10->2'b00 transitions per window: k_ovf=1, k_out=4'hF, lock=0 for every report.
- s_valid toggling 50% random plus ce gaps, kin=7: results are identical to the continuous case (k_out=7). s_ready=0 exactly during REPORT cycles; no sample is lost.
- rst asserted at sample 100 of a window, then kin=2 stream: all outputs return to reset values next cycle. First k_valid comes 257 accepted samples after reset (seed + 256), with k_out=2 and lock=0.

Source files
------------

// File: rtl/dds_freq_detector.sv
// dds_freq_detector: recovers the 4-bit DDS step word from a stream of
// quadrature (sin, cos) samples. It counts quadrant 4 -> quadrant 1 phase
// wraps over a fixed window of accepted samples and reports lock when two
// consecutive windows agree.
module dds_freq_detector #(
    parameter int ROM_AW   = 8,
    parameter int ROM_DW   = 8,
    parameter int WIN_LOG2 = 8,
    parameter int CNT_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [ROM_DW:0]   sin_in,
    input  logic signed [ROM_DW:0]   cos_in,
    output logic [3:0]               k_out,
    output logic                     k_valid,
    output logic                     k_ovf,
    output logic                     lock
);

    // A 4-bit step only stays below a quarter phase cycle when the source
    // accumulator has at least 6 bits, and overflow needs counts above 15.
    if (ROM_AW < 6 || CNT_W < 5 || WIN_LOG2 < 1) begin : g_bad_params
        $error("dds_freq_detector: need ROM_AW >= 6, CNT_W >= 5, WIN_LOG2 >= 1");
    end

    typedef enum logic [1:0] {
        SEED,
        MEAS,
        REPORT
    } state_e;

    localparam logic [WIN_LOG2:0] WinLen  = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0]  WrapMax = '1;

    state_e            state_q, state_d;
    logic [1:0]        prevQuad_q, prevQuad_d;
    logic [WIN_LOG2:0] winCnt_q, winCnt_d;
    logic [CNT_W-1:0]  wrapCnt_q, wrapCnt_d;
    logic [3:0]        lastK_q, lastK_d;
    logic              lastOk_q, lastOk_d;
    logic [3:0]        kOut_q, kOut_d;
    logic              kOvf_q, kOvf_d;
    logic              lock_q, lock_d;

    logic       accept;
    logic [1:0] quad;
    logic       wrapEvent;
    logic       ovf;
    logic       unusedLsbs;

    // Only the sign bits carry quadrant information; magnitudes are ignored.
    assign unusedLsbs = ^{sin_in[ROM_DW-1:0], cos_in[ROM_DW-1:0]};

    assign s_ready   = (state_q != REPORT);
    assign k_valid   = (state_q == REPORT);
    assign accept    = ce & s_valid & s_ready;
    assign quad      = {sin_in[ROM_DW], cos_in[ROM_DW]};
    assign wrapEvent = (prevQuad_q == 2'b10) && (quad == 2'b00);
    assign ovf       = (wrapCnt_q > CNT_W'(15));
    assign k_out     = kOut_q;
    assign k_ovf     = kOvf_q;
    assign lock      = lock_q;

    // Next-state logic: seed the quadrant history, count wraps across the window, then publish one estimate.
    always_comb begin
        state_d    = state_q;
        prevQuad_d = prevQuad_q;
        winCnt_d   = winCnt_q;
        wrapCnt_d  = wrapCnt_q;
        lastK_d    = lastK_q;
        lastOk_d   = lastOk_q;
        kOut_d     = kOut_q;
        kOvf_d     = kOvf_q;
        lock_d     = lock_q;
        case (state_q)
            SEED: begin
                if (accept) begin
                    prevQuad_d = quad;
                    state_d    = MEAS;
                end
            end
            MEAS: begin
                if (accept) begin
                    prevQuad_d = quad;
                    if (wrapEvent && (wrapCnt_q != WrapMax)) begin
                        wrapCnt_d = wrapCnt_q + CNT_W'(1);
                    end
                    winCnt_d = winCnt_q + (WIN_LOG2 + 1)'(1);
                    if (winCnt_d == WinLen) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                kOut_d    = ovf ? 4'hF : wrapCnt_q[3:0];
                kOvf_d    = ovf;
                lock_d    = lastOk_q & ~ovf & (wrapCnt_q[3:0] == lastK_q);
                lastK_d   = wrapCnt_q[3:0];
                lastOk_d  = ~ovf;
                wrapCnt_d = '0;
                winCnt_d  = '0;
                state_d   = MEAS;
            end
            default: begin
                state_d = SEED;
            end
        endcase
    end

    // State register: reset dominates, and everything freezes while ce is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEED;
            prevQuad_q <= 2'b00;
            winCnt_q   <= '0;
            wrapCnt_q  <= '0;
            lastK_q    <= 4'h0;
            lastOk_q   <= 1'b0;
            kOut_q     <= 4'h0;
            kOvf_q     <= 1'b0;
            lock_q     <= 1'b0;
        end else if (ce) begin
            state_q    <= state_d;
            prevQuad_q <= prevQuad_d;
            winCnt_q   <= winCnt_d;
            wrapCnt_q  <= wrapCnt_d;
            lastK_q    <= lastK_d;
            lastOk_q   <= lastOk_d;
            kOut_q     <= kOut_d;
            kOvf_q     <= kOvf_d;
            lock_q     <= lock_d;
        end
    end

endmodule
